// File: rtl/shift_deserializer8_if.sv
// Handshake and data bundle between a serial-in deserializer and its consumer.
// The master drives frame control and serial data; the slave returns the assembled word.
interface shift_deserializer8_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic             shift_en;
  logic             serial_in;
  logic             ack;
  logic [WIDTH-1:0] data_out;
  logic             valid;
  logic             busy;
  logic             overrun;

  modport master (
    output start, shift_en, serial_in, ack,
    input  data_out, valid, busy, overrun
  );

  modport slave (
    input  start, shift_en, serial_in, ack,
    output data_out, valid, busy, overrun
  );
endinterface

// File: rtl/shift_deserializer8.sv
// Serial-in, parallel-out receive register: collects WIDTH strobed bits into a word
// and holds it under a valid/ack handshake, flagging strobes that arrive while pending.
module shift_deserializer8 #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          LSB_FIRST = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  shift_deserializer8_if.slave  bus
);

  localparam int unsigned      CntW    = $clog2(WIDTH);
  localparam logic [CntW-1:0]  LastCnt = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StShift, StHold} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             overrun_q, overrun_d;
  logic [WIDTH-1:0] shifted;

  always_comb begin
    if (LSB_FIRST) begin
      shifted = {bus.serial_in, sreg_q[WIDTH-1:1]};
    end else begin
      shifted = {sreg_q[WIDTH-2:0], bus.serial_in};
    end
  end

  always_comb begin
    state_d   = state_q;
    sreg_d    = sreg_q;
    cnt_d     = cnt_q;
    data_d    = data_q;
    valid_d   = valid_q;
    busy_d    = busy_q;
    overrun_d = overrun_q;

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          state_d   = StShift;
          sreg_d    = '0;
          cnt_d     = '0;
          busy_d    = 1'b1;
          overrun_d = 1'b0;
        end
      end
      StShift: begin
        if (bus.shift_en) begin
          sreg_d = shifted;
          if (cnt_q == LastCnt) begin
            state_d = StHold;
            cnt_d   = '0;
            data_d  = shifted;
            valid_d = 1'b1;
            busy_d  = 1'b0;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end
      StHold: begin
        if (bus.shift_en) begin
          overrun_d = 1'b1;
        end
        if (bus.ack) begin
          valid_d = 1'b0;
          if (bus.start) begin
            // Back-to-back frame; an accepted start clears overrun even on a same-cycle strobe.
            state_d   = StShift;
            sreg_d    = '0;
            cnt_d     = '0;
            busy_d    = 1'b1;
            overrun_d = 1'b0;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      sreg_q    <= '0;
      cnt_q     <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sreg_q    <= sreg_d;
      cnt_q     <= cnt_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      overrun_q <= overrun_d;
    end
  end

  assign bus.data_out = data_q;
  assign bus.valid    = valid_q;
  assign bus.busy     = busy_q;
  assign bus.overrun  = overrun_q;

endmodule

// File: tb/tb_shift_deserializer8.sv
// Bench for shift_deserializer8: an LSB-first and an MSB-first instance share stimulus
// and are compared every cycle against a bit-list reference model plus directed checks.
module tb_shift_deserializer8;
  localparam int unsigned W = 8;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  shift_deserializer8_if #(.WIDTH(W)) bus_l ();
  shift_deserializer8_if #(.WIDTH(W)) bus_m ();

  shift_deserializer8 #(.WIDTH(W), .LSB_FIRST(1'b1)) dut_l (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus_l.slave)
  );

  shift_deserializer8 #(.WIDTH(W), .LSB_FIRST(1'b0)) dut_m (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus_m.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: list of received bits per instance, assembled on completion.
  logic [W-1:0] m_data  [2];
  bit           m_valid [2];
  bit           m_busy  [2];
  bit           m_ovr   [2];
  bit           m_bits  [2][W];
  int           m_n     [2];

  logic [7:0] team_reg;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_step(input int m, input bit lsb, input bit rn, input bit st,
                                     input bit se, input bit si, input bit ak);
    if (!rn) begin
      m_data[m]  = '0;
      m_valid[m] = 1'b0;
      m_busy[m]  = 1'b0;
      m_ovr[m]   = 1'b0;
      m_n[m]     = 0;
      return;
    end
    if (m_busy[m]) begin
      if (se) begin
        m_bits[m][m_n[m]] = si;
        m_n[m]++;
        if (m_n[m] == W) begin
          for (int i = 0; i < W; i++) begin
            if (lsb) m_data[m][i] = m_bits[m][i];
            else     m_data[m][W-1-i] = m_bits[m][i];
          end
          m_valid[m] = 1'b1;
          m_busy[m]  = 1'b0;
          m_n[m]     = 0;
        end
      end
    end else if (m_valid[m]) begin
      if (se) m_ovr[m] = 1'b1;
      if (ak) begin
        m_valid[m] = 1'b0;
        if (st) begin
          m_busy[m] = 1'b1;
          m_n[m]    = 0;
          m_ovr[m]  = 1'b0;
        end
      end
    end else if (st) begin
      m_busy[m] = 1'b1;
      m_n[m]    = 0;
      m_ovr[m]  = 1'b0;
    end
  endfunction

  task automatic cycle(input bit rn, input bit st, input bit se, input bit si, input bit ak);
    reset_n         = rn;
    bus_l.start     = st;
    bus_l.shift_en  = se;
    bus_l.serial_in = si;
    bus_l.ack       = ak;
    bus_m.start     = st;
    bus_m.shift_en  = se;
    bus_m.serial_in = si;
    bus_m.ack       = ak;
    @(posedge clk);
    model_step(0, 1'b1, rn, st, se, si, ak);
    model_step(1, 1'b0, rn, st, se, si, ak);
    #1;
    check_eq("l_data",    bus_l.data_out, m_data[0]);
    check_eq("l_valid",   bus_l.valid,    m_valid[0]);
    check_eq("l_busy",    bus_l.busy,     m_busy[0]);
    check_eq("l_overrun", bus_l.overrun,  m_ovr[0]);
    check_eq("m_data",    bus_m.data_out, m_data[1]);
    check_eq("m_valid",   bus_m.valid,    m_valid[1]);
    check_eq("m_busy",    bus_m.busy,     m_busy[1]);
    check_eq("m_overrun", bus_m.overrun,  m_ovr[1]);
  endtask

  // seq[i] is the i-th bit on the line.
  task automatic send_bits(input logic [7:0] seq, input bit do_start, input int max_gap,
                           input bit mid_start);
    if (do_start) cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < W; i++) begin
      int gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
      for (int g = 0; g < gap; g++) cycle(1'b1, mid_start && (i == 4), 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 1'b0, 1'b1, seq[i], 1'b0);
    end
  endtask

  initial begin
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    check_eq("rst_data",  bus_l.data_out, 8'h00);
    check_eq("rst_valid", bus_l.valid,    1'b0);
    check_eq("rst_busy",  bus_l.busy,     1'b0);
    check_eq("rst_ovr",   bus_l.overrun,  1'b0);

    // 1: plain frame, valid one cycle after the 8th strobe
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    check_eq("t1_busy_after_start", bus_l.busy, 1'b1);
    send_bits(8'hA5, 1'b0, 0, 1'b0);
    check_eq("t1_valid", bus_l.valid,    1'b1);
    check_eq("t1_busy",  bus_l.busy,     1'b0);
    check_eq("t1_data",  bus_l.data_out, 8'hA5);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    check_eq("t1_valid_ack", bus_l.valid,    1'b0);
    check_eq("t1_data_kept", bus_l.data_out, 8'hA5);

    // 2: gaps and a mid-frame start
    send_bits(8'hA5, 1'b1, 3, 1'b1);
    check_eq("t2_data",  bus_l.data_out, 8'hA5);
    check_eq("t2_valid", bus_l.valid,    1'b1);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);

    // 3: reset mid-frame, then a fresh frame
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    check_eq("t3_rst_data",  bus_l.data_out, 8'h00);
    check_eq("t3_rst_valid", bus_l.valid,    1'b0);
    check_eq("t3_rst_busy",  bus_l.busy,     1'b0);
    // Strobes right after reset must be ignored in idle.
    cycle(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    check_eq("t3_idle_busy", bus_l.busy, 1'b0);
    send_bits(8'h3C, 1'b1, 0, 1'b0);
    check_eq("t3_data", bus_l.data_out, 8'h3C);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);

    // 4: overrun in hold, then ack+start back-to-back
    send_bits(8'hFF, 1'b1, 0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    check_eq("t4_start_no_ack", bus_l.valid, 1'b1);
    cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    check_eq("t4_ovr",       bus_l.overrun,  1'b1);
    check_eq("t4_data_held", bus_l.data_out, 8'hFF);
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    check_eq("t4_b2b_valid", bus_l.valid,   1'b0);
    check_eq("t4_b2b_busy",  bus_l.busy,    1'b1);
    check_eq("t4_b2b_ovr",   bus_l.overrun, 1'b0);
    send_bits(8'h01, 1'b0, 0, 1'b0);
    check_eq("t4_data_l", bus_l.data_out, 8'h01);
    check_eq("t4_data_m", bus_m.data_out, 8'h80);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);

    // 5: MSB-first ordering
    send_bits(8'hA5, 1'b1, 1, 1'b0);
    check_eq("t5_a5_m", bus_m.data_out, 8'hA5);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    send_bits(8'h03, 1'b1, 1, 1'b0);
    check_eq("t5_c0_m", bus_m.data_out, 8'hC0);
    check_eq("t5_03_l", bus_l.data_out, 8'h03);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);

    // 6: loopback from a right-shifting load/shift register
    team_reg = 8'h96;
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, 1'b0, 1'b1, team_reg[0], 1'b0);
      team_reg = team_reg >> 1;
    end
    check_eq("t6_loopback", bus_l.data_out, 8'h96);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);

    // Random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      cycle(($urandom_range(63, 0) != 0), ($urandom_range(3, 0) == 0),
            $urandom_range(1, 0) == 1, $urandom_range(1, 0) == 1,
            ($urandom_range(3, 0) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/shift_deserializer8.md
Name: shift_deserializer8

Overview:
- Serial-in, parallel-out receive register; the receiving end of the team's 8-bit right-shifting load/shift register, whose serial output is bit 0.
- Collects WIDTH bits from a 1-bit serial line, one bit per strobe, and presents the assembled word with a valid/ack handshake.
- Sits between a serial link (switches, another board's shifter output) and LEDR/HEX display or downstream logic.

Parameters:
- WIDTH, 8, number of bits per frame (2..16).
- LSB_FIRST, 1, 1 = the first received bit lands in data_out[0]; 0 = the first received bit lands in data_out[WIDTH-1].

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  reset; one clock, synchronous, active-low.
- start  input  1  begin a new frame (level sampled per cycle).
- shift_en  input  1  bit strobe; serial_in is valid in the same cycle.
- serial_in  input  1  serial data bit.
- ack  input  1  consumer has taken data_out.
- data_out  output  WIDTH  last completed frame.
- valid  output  1  data_out holds an unacknowledged frame.
- busy  output  1  frame reception in progress.
- overrun  output  1  sticky: a bit strobe arrived while a frame was pending.

Behaviour:
- Reset (reset_n=0 at a clk edge) overrides everything, including mid-frame:
  - state=IDLE, shift register=0, bit count=0.
  - data_out=0, valid=0, busy=0, overrun=0.
- FSM states: IDLE, SHIFT, HOLD. All outputs are registered.
- IDLE:
  - start=1 -> SHIFT next cycle; shift register and count are cleared; overrun is cleared.
  - shift_en is ignored.
  - busy=1 from the cycle after start is accepted.
- SHIFT, each cycle with shift_en=1:
  - LSB_FIRST=1: sreg <= {serial_in, sreg[WIDTH-1:1]}.
  - LSB_FIRST=0: sreg <= {sreg[WIDTH-2:0], serial_in}.
  - count increments.
  - shift_en=0 holds sreg and count; gaps of any length are legal.
  - start is ignored (no restart mid-frame).
- Frame completion, when shift_en=1 and count=WIDTH-1:
  - data_out <= the final shifted value, including this bit.
  - valid=1 and busy=0 from the next cycle; state -> HOLD; count -> 0.
  - Latency: valid rises exactly one cycle after the WIDTH-th accepted strobe.
- HOLD:
  - data_out and valid are held until ack=1.
  - ack=1, start=0 -> IDLE; valid=0 next cycle.
  - ack=1, start=1 in the same cycle -> SHIFT directly (back-to-back frame); valid=0, busy=1 next cycle; sreg cleared; overrun cleared.
  - start=1 without ack is ignored.
  - shift_en=1 in HOLD discards the bit and sets overrun=1. overrun stays set until the next accepted start or reset.
- ack outside HOLD is ignored.
- data_out is updated only on frame completion; it keeps its value through IDLE and the next SHIFT.
- count width is ceil(log2(WIDTH)); it never exceeds WIDTH-1 and has no wrap beyond the frame.

Test Plan:
1. Reset, then start, then 8 consecutive strobes carrying serial_in = 1,0,1,0,0,1,0,1 (LSB_FIRST=1) -> valid=1 with data_out=8'hA5 one cycle after the 8th strobe; busy=0; after ack, valid=0 while data_out stays 8'hA5.
2. Same frame with 0-3 idle cycles of shift_en=0 between bits, plus a start pulse mid-frame -> identical result, 8'hA5; the mid-frame start has no effect.
3. Reset asserted after 4 bits of a frame -> next cycle all outputs 0 and state IDLE; a fresh start followed by 8'h3C (bits 0,0,1,1,1,1,0,0) -> data_out=8'h3C.
4. Frame 8'hFF completes and sits pending; 2 strobes in HOLD -> overrun=1 and data_out stays 8'hFF; ack+start in the same cycle -> valid=0, busy=1, overrun=0 next cycle; next frame 8'h01 -> data_out=8'h01.
5. LSB_FIRST=0, bits 1,0,1,0,0,1,0,1 -> data_out=8'hA5; bits 1,1,0,0,0,0,0,0 -> data_out=8'hC0.
6. Loopback: the team's shift register loaded with 8'h96 and shifted right 8 times, its q[0] driving serial_in and shift_en tied to its shift strobes -> data_out=8'h96.
